// File: rtl/adder_share_pkg.sv
// Shared widths and response-slot state encoding for the shared-adder arbiter.
package adder_share_pkg;

   localparam int OP_W  = 2;
   localparam int SUM_W = 3;
   localparam int CNT_W = 16;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, with wrap-around.
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    valid,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] gidx,
   output logic            any_grant
);

   int j;

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      grant     = '0;
      gidx      = '0;
      any_grant = 1'b0;
      j         = 0;
      // Walk from the farthest offset down so the nearest valid requester wins.
      for (int i = N - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % N;
         if (valid[j]) begin
            grant     = '0;
            grant[j]  = 1'b1;
            gidx      = ID_W'(j);
            any_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sharing of one 2+2->3 bit adder among N_REQ requesters, with a single
// registered response slot and a completed-response counter.
module adder_share_arb
   import adder_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [OP_W*N_REQ-1:0] req_a,
   input  logic [OP_W*N_REQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [SUM_W-1:0]      rsp_sum,
   output logic [ID_W-1:0]       rsp_id,
   output logic [CNT_W-1:0]      ops_done
);

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [N_REQ-1:0]  pick_grant;
   logic [ID_W-1:0]   pick_idx;
   logic              pick_any;
   logic              slot_free;
   logic              accept;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic [SUM_W-1:0]  sum_next;
   logic [ID_W-1:0]   ptr_next;

   rr_pick #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_pick (
      .valid     (req_valid),
      .ptr       (ptr),
      .grant     (pick_grant),
      .gidx      (pick_idx),
      .any_grant (pick_any)
   );

   // The slot may drain and refill on the same edge.
   assign slot_free = (state == S_EMPTY) || rsp_ready;
   assign accept    = slot_free && pick_any && !rst;
   assign req_ready = accept ? pick_grant : '0;

   assign op_a     = req_a[pick_idx*OP_W +: OP_W];
   assign op_b     = req_b[pick_idx*OP_W +: OP_W];
   assign sum_next = SUM_W'(op_a) + SUM_W'(op_b);
   assign ptr_next = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;

   assign rsp_valid = (state == S_FULL);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_EMPTY;
         rsp_sum  <= '0;
         rsp_id   <= '0;
         ptr      <= '0;
         ops_done <= '0;
      end else begin
         if (accept) begin
            state   <= S_FULL;
            rsp_sum <= sum_next;
            rsp_id  <= pick_idx;
            ptr     <= ptr_next;
         end else if (rsp_ready) begin
            state <= S_EMPTY;
         end
         if (rsp_valid && rsp_ready) begin
            ops_done <= ops_done + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: vector table plus backpressure, reset, rotation and wrap sequences.
module tb_adder_share_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [7:0]  req_a;
   logic [7:0]  req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [2:0]  rsp_sum;
   logic [1:0]  rsp_id;
   logic [15:0] ops_done;

   int n_vec = 0;
   int n_err = 0;

   adder_share_arb #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .ops_done  (ops_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] valid;
      logic [7:0] a;
      logic [7:0] b;
      logic       rr;
      logic [3:0] exp_rdy;
      logic       exp_v;
      logic [2:0] exp_sum;
      logic [1:0] exp_id;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   logic [15:0] ops_model;
   logic        exp_v_prev;
   int          seq_err;
   longint      acc;

   initial begin
      // a = {3,2,1,0}, b = {1,1,1,1} for the multi-requester vectors
      vecs[0]  = '{4'b0100, 8'h30, 8'h30, 1'b1, 4'b0100, 1'b1, 3'd6, 2'd2};
      vecs[1]  = '{4'b0010, 8'h00, 8'h00, 1'b1, 4'b0010, 1'b1, 3'd0, 2'd1};
      vecs[2]  = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 3'd0, 2'd0};
      vecs[3]  = '{4'b1111, 8'hE4, 8'h55, 1'b1, 4'b0100, 1'b1, 3'd3, 2'd2};
      vecs[4]  = '{4'b1111, 8'hE4, 8'h55, 1'b1, 4'b1000, 1'b1, 3'd4, 2'd3};
      vecs[5]  = '{4'b1111, 8'hE4, 8'h55, 1'b1, 4'b0001, 1'b1, 3'd1, 2'd0};
      vecs[6]  = '{4'b1111, 8'hE4, 8'h55, 1'b1, 4'b0010, 1'b1, 3'd2, 2'd1};
      vecs[7]  = '{4'b1001, 8'hE4, 8'h55, 1'b0, 4'b0000, 1'b1, 3'd2, 2'd1};
      vecs[8]  = '{4'b1001, 8'hE4, 8'h55, 1'b1, 4'b1000, 1'b1, 3'd4, 2'd3};
      vecs[9]  = '{4'b1001, 8'hE4, 8'h55, 1'b1, 4'b0001, 1'b1, 3'd1, 2'd0};
      vecs[10] = '{4'b0000, 8'hE4, 8'h55, 1'b0, 4'b0000, 1'b1, 3'd1, 2'd0};
      vecs[11] = '{4'b0000, 8'hE4, 8'h55, 1'b1, 4'b0000, 1'b0, 3'd0, 2'd0};

      rst       = 1'b1;
      req_valid = 4'b1111;
      req_a     = 8'hFF;
      req_b     = 8'hFF;
      rsp_ready = 1'b1;
      #1;
      check("rst_rdy", 32'(req_ready), 32'd0);
      cyc();
      cyc();
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_sum", 32'(rsp_sum), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_ops", 32'(ops_done), 32'd0);
      rst = 1'b0;

      ops_model  = '0;
      exp_v_prev = 1'b0;
      for (int i = 0; i < 12; i++) begin
         req_valid = vecs[i].valid;
         req_a     = vecs[i].a;
         req_b     = vecs[i].b;
         rsp_ready = vecs[i].rr;
         #1;
         check($sformatf("v%0d_rdy", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
         if (exp_v_prev && vecs[i].rr) ops_model = ops_model + 1'b1;
         cyc();
         check($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_v));
         if (vecs[i].exp_v) begin
            check($sformatf("v%0d_sum", i), 32'(rsp_sum), 32'(vecs[i].exp_sum));
            check($sformatf("v%0d_id", i), 32'(rsp_id), 32'(vecs[i].exp_id));
         end
         check($sformatf("v%0d_ops", i), 32'(ops_done), 32'(ops_model));
         exp_v_prev = vecs[i].exp_v;
      end

      // Backpressure: load 2+3 from requester 0, hold for 3 cycles, then grant 1 on drain.
      req_valid = 4'b0000;
      do_reset();
      req_valid = 4'b0001;
      req_a     = 8'h02;
      req_b     = 8'h03;
      rsp_ready = 1'b0;
      #1;
      check("bp_load_rdy", 32'(req_ready), 32'b0001);
      cyc();
      req_valid = 4'b0110;
      req_a     = 8'hE4;
      req_b     = 8'h55;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_hold_rdy", 32'(req_ready), 32'd0);
         cyc();
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_sum", 32'(rsp_sum), 32'd5);
         check("bp_hold_id", 32'(rsp_id), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_resume_rdy", 32'(req_ready), 32'b0010);
      cyc();
      check("bp_resume_sum", 32'(rsp_sum), 32'd2);
      check("bp_resume_id", 32'(rsp_id), 32'd1);
      check("bp_resume_ops", 32'(ops_done), 32'd1);

      // Reset while FULL with requesters 1 and 3 pending (ptr is 2 before reset).
      req_valid = 4'b1010;
      rsp_ready = 1'b0;
      cyc();
      rst       = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check("mrst_rdy", 32'(req_ready), 32'd0);
      cyc();
      rst = 1'b0;
      check("mrst_valid", 32'(rsp_valid), 32'd0);
      check("mrst_ops", 32'(ops_done), 32'd0);
      #1;
      check("mrst_first_rdy", 32'(req_ready), 32'b0010);
      cyc();
      check("mrst_first_id", 32'(rsp_id), 32'd1);
      check("mrst_first_sum", 32'(rsp_sum), 32'd2);

      // Continuous requests from all four: strict rotation 0,1,2,3,0,1.
      req_valid = 4'b1111;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("rot%0d_rdy", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         cyc();
         check($sformatf("rot%0d_id", k), 32'(rsp_id), 32'(k % 4));
         check($sformatf("rot%0d_sum", k), 32'(rsp_sum), 32'(k % 4 + 1));
      end

      // Counter wrap: 65537 responses loaded, 65536 drained.
      do_reset();
      seq_err = 0;
      acc     = 0;
      for (int k = 0; k <= 65536; k++) begin
         cyc();
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== 3'(k % 4 + 1))
            seq_err++;
         acc += longint'(rsp_sum);
         if (k == 65535) check("wrap_ops_max", 32'(ops_done), 32'd65535);
      end
      check("wrap_ops_zero", 32'(ops_done), 32'd0);
      check("wrap_seq_errors", 32'(seq_err), 32'd0);
      check("wrap_sum_total", 32'(acc), 32'd163841);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
